// File: rtl/aes_key_schedule_if.sv
// rtl/aes_key_schedule_if.sv - request, status and round-key read bundle of the AES-128 key schedule
interface aes_key_schedule_if;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    modport master (
        output start, key, rd_idx,
        input  busy, ready, rd_key
    );

    modport slave (
        input  start, key, rd_idx,
        output busy, ready, rd_key
    );
endinterface

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128 key expansion, one round key per clock into an 11-entry file
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the bit offset uses the inverted index.
    logic [10:0] bit_lo;
    assign bit_lo = {~din, 3'b000};
    assign dout   = SBOX[bit_lo +: 8];
endmodule

module aes_key_schedule (
    input  logic                  clk,
    input  logic                  rst,
    aes_key_schedule_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state;
    logic [3:0]   cnt;
    logic [7:0]   rcon;
    logic [127:0] rk [0:10];
    // Copy of rk[cnt-1], avoiding an 11-way read mux in the expansion path.
    logic [127:0] prev_key;

    logic [31:0]  w0, w1, w2, w3, rot_w3, sub_w3, t;
    logic [127:0] next_key;

    assign {w0, w1, w2, w3} = prev_key;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    aes_sbox u_sbox0 (.din(rot_w3[31:24]), .dout(sub_w3[31:24]));
    aes_sbox u_sbox1 (.din(rot_w3[23:16]), .dout(sub_w3[23:16]));
    aes_sbox u_sbox2 (.din(rot_w3[15:8]),  .dout(sub_w3[15:8]));
    aes_sbox u_sbox3 (.din(rot_w3[7:0]),   .dout(sub_w3[7:0]));

    assign t = sub_w3 ^ {rcon, 24'h0};
    assign next_key[127:96] = w0 ^ t;
    assign next_key[95:64]  = next_key[127:96] ^ w1;
    assign next_key[63:32]  = next_key[95:64] ^ w2;
    assign next_key[31:0]   = next_key[63:32] ^ w3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.ready <= 1'b0;
            cnt      <= 4'd0;
            rcon     <= 8'h01;
            prev_key <= 128'h0;
            for (int i = 0; i <= 10; i++) begin
                rk[i] <= 128'h0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        rk[0]     <= bus.key;
                        prev_key  <= bus.key;
                        cnt       <= 4'd1;
                        rcon      <= 8'h01;
                        state     <= EXPAND;
                        bus.busy  <= 1'b1;
                        bus.ready <= 1'b0;
                    end
                end
                EXPAND: begin
                    for (int i = 1; i <= 10; i++) begin
                        if (cnt == 4'(i)) begin
                            rk[i] <= next_key;
                        end
                    end
                    prev_key <= next_key;
                    cnt      <= cnt + 4'd1;
                    rcon     <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                    if (cnt == 4'd10) begin
                        state     <= DONE;
                        bus.busy  <= 1'b0;
                        bus.ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.busy  <= 1'b0;
                    bus.ready <= 1'b0;
                end
            endcase
        end
    end

    // Indices 11..15 fall through to zero.
    always_comb begin
        bus.rd_key = 128'h0;
        for (int i = 0; i <= 10; i++) begin
            if (bus.rd_idx == 4'(i)) begin
                bus.rd_key = rk[i];
            end
        end
    end
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - directed and random checks of aes_key_schedule against a word-level FIPS-197 model
module tb_aes_key_schedule;
    logic clk;
    logic rst;
    aes_key_schedule_if bus ();

    aes_key_schedule dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]          sb [256];
    logic [10:0][127:0]  exp_rk;
    logic [10:0][127:0]  got;
    int                  edges;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] K3_KEY    = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] K3_RK1    = 128'hdc9037b09b49dfe997fe723f388115a7;
    localparam logic [127:0] K3_PT     = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] K3_CT     = 128'hff0b844a0853bf7c6934ab4364148fb9;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from first principles: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [10:0][127:0] ref_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        logic [10:0][127:0] r;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 11; n++) r[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
        return r;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [10:0][127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [127:0] v = pt ^ k[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[v[127 - 8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) u[4*c + q] = s[4*((c + q) % 4) + q];
            for (int c = 0; c < 4; c++) begin
                if (r != 10) begin
                    s[4*c]   = gmul(u[4*c], 2) ^ gmul(u[4*c+1], 3) ^ u[4*c+2] ^ u[4*c+3];
                    s[4*c+1] = u[4*c] ^ gmul(u[4*c+1], 2) ^ gmul(u[4*c+2], 3) ^ u[4*c+3];
                    s[4*c+2] = u[4*c] ^ u[4*c+1] ^ gmul(u[4*c+2], 2) ^ gmul(u[4*c+3], 3);
                    s[4*c+3] = gmul(u[4*c], 3) ^ u[4*c+1] ^ u[4*c+2] ^ gmul(u[4*c+3], 2);
                end else begin
                    for (int q = 0; q < 4; q++) s[4*c+q] = u[4*c+q];
                end
            end
            for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = s[i];
            v = v ^ k[r];
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rk(input int idx, output logic [127:0] v);
        bus.rd_idx = 4'(idx);
        #1;
        v = bus.rd_key;
    endtask

    task automatic read_all();
        for (int i = 0; i < 11; i++) read_rk(i, got[i]);
    endtask

    task automatic check_file(input string tag, input logic [10:0][127:0] exp);
        logic [127:0] v;
        for (int i = 0; i < 11; i++) begin
            read_rk(i, v);
            check($sformatf("%s rk[%0d]", tag, i), v, exp[i]);
        end
    endtask

    // Drives a start pulse, then scrambles key so only the accepting edge can capture it.
    task automatic pulse_start(input logic [127:0] k);
        bus.start = 1'b1;
        bus.key   = k;
        tick();
        bus.start = 1'b0;
        bus.key   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Counts edges after the start edge until ready; overlap of busy and ready counts as an error.
    task automatic wait_ready(input int already, output int n);
        logic overlap = 1'b0;
        n = already;
        while (!bus.ready && n < 20) begin
            tick();
            n++;
            if (bus.busy && bus.ready) overlap = 1'b1;
        end
        check_bit("busy_ready_exclusive", overlap, 1'b0);
    endtask

    initial begin
        build_sbox();
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.key    = 128'h0;
        bus.rd_idx = 4'd0;
        tick();
        tick();
        rst = 1'b0;

        check_bit("reset busy", bus.busy, 1'b0);
        check_bit("reset ready", bus.ready, 1'b0);
        check_file("reset", '0);

        // FIPS-197 key
        pulse_start(FIPS_KEY);
        check_bit("fips busy after E0", bus.busy, 1'b1);
        check_bit("fips ready after E0", bus.ready, 1'b0);
        wait_ready(0, edges);
        check_int("fips latency", edges, 10);
        check_bit("fips busy at done", bus.busy, 1'b0);
        read_all();
        check("fips rk0", got[0], FIPS_KEY);
        check("fips rk1", got[1], FIPS_RK1);
        check("fips rk10", got[10], FIPS_RK10);
        check_file("fips model", ref_expand(FIPS_KEY));

        for (int i = 11; i < 16; i++) begin
            logic [127:0] v;
            read_rk(i, v);
            check($sformatf("oob rd_idx %0d", i), v, 128'h0);
        end

        // Restart from DONE with the zero key
        pulse_start(128'h0);
        check_bit("restart ready drops", bus.ready, 1'b0);
        wait_ready(0, edges);
        check_int("restart latency", edges, 10);
        read_all();
        check("zero rk1", got[1], ZERO_RK1);
        check("zero rk10", got[10], ZERO_RK10);

        // Third key, then encrypt with the round keys read back
        pulse_start(K3_KEY);
        wait_ready(0, edges);
        check_int("k3 latency", edges, 10);
        read_all();
        check("k3 rk1", got[1], K3_RK1);
        check("k3 ciphertext", aes_enc(K3_PT, got), K3_CT);

        // Start while busy must be ignored
        pulse_start(FIPS_KEY);
        tick();
        tick();
        tick();
        bus.start = 1'b1;
        bus.key   = 128'h0;
        tick();
        bus.start = 1'b0;
        check_bit("start-while-busy still busy", bus.busy, 1'b1);
        wait_ready(4, edges);
        check_int("start-while-busy latency", edges, 10);
        read_all();
        check("start-while-busy rk10", got[10], FIPS_RK10);
        check("start-while-busy rk0", got[0], FIPS_KEY);

        // Reset at E5 aborts the run
        pulse_start(K3_KEY);
        for (int i = 1; i <= 4; i++) tick();
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check_bit("abort busy", bus.busy, 1'b0);
        check_bit("abort ready", bus.ready, 1'b0);
        check_file("abort", '0);
        tick();
        check_bit("abort ready stays low", bus.ready, 1'b0);

        // Random keys against the reference model
        for (int r = 0; r < 6; r++) begin
            logic [127:0] k;
            k = {$urandom, $urandom, $urandom, $urandom};
            exp_rk = ref_expand(k);
            pulse_start(k);
            wait_ready(0, edges);
            check_int($sformatf("rand%0d latency", r), edges, 10);
            check_file($sformatf("rand%0d", r), exp_rk);
            for (int i = 0; i < $urandom_range(0, 3); i++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key expansion unit that sits directly upstream of the `encryptor` datapath. It takes the 128-bit cipher key, computes round keys 0..10 at one per clock, and holds them in an internal 11-entry round-key file. The encryptor (and later the decryptor, in reverse order) reads the file by round index. Expansion is a fixed 10-cycle operation, and the file stays valid until the next start.

## Interface
Parameters:
- none. Fixed AES-128: Nk=4, Nr=10, 11 round keys.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  one-cycle request to expand `key`. Ignored unless the state is IDLE or DONE.
- `key`  in  128  cipher key, MSB = byte 0. Sampled only on the edge that accepts `start`.
- `busy`  out  1  high while expansion is in progress (EXPAND state).
- `ready`  out  1  high while all 11 round keys are valid (DONE state).
- `rd_idx`  in  4  round-key index to read, 0..10.
- `rd_key`  out  128  round key `rd_idx`; combinational read of the key file.

## Operation
- States:
  - IDLE: after reset.
  - EXPAND: `busy`=1.
  - DONE: `ready`=1.
- IDLE or DONE, with `start`=1:
  - rk[0] <= `key`, cnt <= 1, rcon <= 8'h01.
  - Go to EXPAND; `ready` drops on the same edge.
- EXPAND, each edge:
  - Previous key = rk[cnt-1], words w0..w3.
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - rk[cnt] <= {w0^t, w0^w1^t, w0^w1^w2^t, w0^w1^w2^w3^t}.
  - cnt <= cnt+1.
  - rcon <= xtime(rcon): shift left 1; if bit 7 was set, XOR 8'h1b.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- The EXPAND edge that writes rk[10] moves the state to DONE.
- SubWord uses four instances of the team's byte S-box, the same module `encryptor` uses for SubBytes.
- `start` during EXPAND is ignored: no restart and no key capture. A bench must check this.
- `key` changes outside the accepting edge have no effect.
- Read path:
  - `rd_key` = rk[`rd_idx`] for `rd_idx` 0..10.
  - `rd_idx` 11..15 returns 128'h0.
  - Reads are legal in any state. Entries not yet written in the current run return stale or reset contents, and the consumer must wait for `ready`.
- Reset on any edge with `rst`=1:
  - state=IDLE, `busy`=0, `ready`=0, cnt=0, rcon=8'h01, all rk entries = 128'h0.
  - `rst` overrides `start` on the same edge.
  - Reset mid-EXPAND aborts expansion; `ready` stays 0 until a new full expansion completes.

## Timing
- Reset values: `busy`=0, `ready`=0, `rd_key`=128'h0 for any `rd_idx`.
- `start` accepted at edge E0:
  - rk[0] valid after E0.
  - rk[n] valid after edge En, for n = 1..10.
  - `busy`=1 from after E0 through E10; `busy`=0 after E10.
  - `ready`=1 after E10.
- Latency: 10 cycles from the start edge to `ready`; start-to-start throughput 11 cycles minimum.
- `start` in DONE restarts: `ready`=0 after that edge, and it returns 10 edges later.
- `rd_key` follows `rd_idx` combinationally, in the same cycle. No registered output stage.
- `busy` and `ready` are never high together.

## Test plan
- FIPS-197 key:
  - Stimulus: `key`=2b7e151628aed2a6abf7158809cf4f3c, start.
  - After `ready`: rk[0]=`key`, rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `ready` rises exactly 10 edges after start.
- All-zero key:
  - rk[1]=62636363626363636263636362636363.
  - rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- Key 0f1571c947d9e8590cb7add6af7f6798:
  - rk[1]=dc9037b09b49dfe997fe723f388115a7.
  - Then run `encryptor` with plaintext 0123456789abcdeffedcba9876543210 using these keys. Required ciphertext ff0b844a0853bf7c6934ab4364148fb9.
- Start while busy:
  - Start the FIPS key, then pulse start with the all-zero key at E4.
  - Required: `ready` still at E10, and rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reset mid-expansion:
  - Assert `rst` at E5.
  - Required next cycle: `busy`=0, `ready`=0, `rd_key`=0 for rd_idx 0..10.
  - A new start completes normally.
- Restart from DONE and out-of-range read:
  - After the FIPS run, start with the zero key. Required: `ready`=0 next cycle and rk[10] updated after 10 edges.
  - `rd_idx`=12 returns 128'h0.
